// File: rtl/apu_sdm_dac_pkg.sv
// Shared APU audio definitions: sample width, full-scale codes and the
// saturating clamp used by the audio integrators.
package apu_sdm_dac_pkg;

    localparam int W_SAMPLE = 16;

    localparam logic signed [15:0] FS_POS = 16'sh7fff;
    localparam logic signed [15:0] FS_NEG = 16'sh8000;

    // Clamp a signed value into the range of a signed field 'width' bits wide.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                               input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            sat = hi;
        end else if (value < lo) begin
            sat = lo;
        end else begin
            sat = value;
        end
    endfunction

endpackage

// File: rtl/apu_sdm_interp.sv
// Linear interpolator: walks cur from its present value to each newly loaded
// sample in 2^LOG2_OSR ticks, landing exactly on the sample at the last tick.
module apu_sdm_interp
    import apu_sdm_dac_pkg::*;
#(
    parameter int W_SAMPLE = apu_sdm_dac_pkg::W_SAMPLE,
    parameter int LOG2_OSR = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       tick,
    input  logic                       load,
    input  logic signed [W_SAMPLE-1:0] d,
    output logic signed [W_SAMPLE-1:0] x
);

    localparam int W_CUR  = W_SAMPLE + LOG2_OSR;
    localparam int W_STEP = W_CUR + 1;
    localparam int W_SUM  = W_STEP + 1;

    logic signed [W_CUR-1:0]    cur_reg;
    logic signed [W_CUR-1:0]    cur_next;
    logic signed [W_CUR-1:0]    cur_ticked;
    logic signed [W_STEP-1:0]   step_reg;
    logic signed [W_STEP-1:0]   step_next;
    logic signed [W_STEP-1:0]   diff;
    logic signed [W_SUM-1:0]    sum;
    logic signed [W_SAMPLE-1:0] target_reg;
    logic signed [W_SAMPLE-1:0] target_next;
    logic        [LOG2_OSR-1:0] phase_reg;
    logic        [LOG2_OSR-1:0] phase_next;

    always_comb begin
        sum         = W_SUM'(cur_reg) + W_SUM'(step_reg);
        cur_ticked  = cur_reg;
        step_next   = step_reg;
        phase_next  = phase_reg;
        target_next = target_reg;

        if (tick) begin
            phase_next = phase_reg + LOG2_OSR'(1);
            if (&phase_reg) begin
                cur_ticked = {target_reg, {LOG2_OSR{1'b0}}};
                step_next  = '0;
            end else begin
                // floor() on a falling ramp can overshoot by a few LSBs near -FS
                cur_ticked = W_CUR'(sat(32'(sum), W_CUR));
            end
        end

        // A load computes its slope from the value this cycle's tick produces.
        diff     = W_STEP'($signed({d, {LOG2_OSR{1'b0}}})) - W_STEP'(cur_ticked);
        cur_next = cur_ticked;
        if (load) begin
            target_next = d;
            step_next   = diff >>> LOG2_OSR;
            phase_next  = '0;
        end

        if (clear) begin
            cur_next    = '0;
            step_next   = '0;
            phase_next  = '0;
            target_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_reg    <= '0;
            step_reg   <= '0;
            phase_reg  <= '0;
            target_reg <= '0;
        end else begin
            cur_reg    <= cur_next;
            step_reg   <= step_next;
            phase_reg  <= phase_next;
            target_reg <= target_next;
        end
    end

    assign x = cur_reg[W_CUR-1:LOG2_OSR];

endmodule

// File: rtl/apu_sdm_dac.sv
// 1-bit pulse-density DAC: interpolated FIR samples feed a saturating
// second-order delta-sigma modulator clocked by an internal tick divider.
module apu_sdm_dac
    import apu_sdm_dac_pkg::*;
#(
    parameter int W_SAMPLE = apu_sdm_dac_pkg::W_SAMPLE,
    parameter int W_ACC    = 20,
    parameter int LOG2_OSR = 4,
    parameter int DIV      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       en,
    input  logic signed [W_SAMPLE-1:0] d,
    output logic                       tick,
    output logic                       dac_out
);

    localparam int W_DIV = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W_MOD = W_ACC + 1;

    logic [W_DIV-1:0]           div_cnt_reg;
    logic                       div_wrap;
    logic                       tick_reg;
    logic                       enable_d_reg;
    logic                       dac_reg;
    logic signed [W_ACC-1:0]    i1_reg;
    logic signed [W_ACC-1:0]    i2_reg;
    logic signed [W_ACC-1:0]    i1_next;
    logic signed [W_ACC-1:0]    i2_next;
    logic signed [W_MOD-1:0]    v;
    logic signed [W_MOD-1:0]    sum1;
    logic signed [W_MOD-1:0]    sum2;
    logic signed [W_SAMPLE-1:0] x;

    assign div_wrap = (div_cnt_reg == W_DIV'(DIV - 1));

    // The divider keeps running while disabled so the idle toggle keeps its rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + W_DIV'(1);
            tick_reg    <= enable & div_wrap;
        end
    end

    apu_sdm_interp #(
        .W_SAMPLE (W_SAMPLE),
        .LOG2_OSR (LOG2_OSR)
    ) u_interp (
        .clk   (clk),
        .rst   (rst),
        .clear (~enable),
        .tick  (tick_reg),
        .load  (en),
        .d     (d),
        .x     (x)
    );

    always_comb begin
        v       = dac_reg ? W_MOD'(FS_POS) : W_MOD'(FS_NEG);
        sum1    = W_MOD'(i1_reg) + W_MOD'(x) - v;
        sum2    = W_MOD'(i2_reg) + W_MOD'(i1_reg) - v;
        i1_next = W_ACC'(sat(32'(sum1), W_ACC));
        i2_next = W_ACC'(sat(32'(sum2), W_ACC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1_reg       <= '0;
            i2_reg       <= '0;
            dac_reg      <= 1'b0;
            enable_d_reg <= 1'b0;
        end else if (!enable) begin
            i1_reg       <= '0;
            i2_reg       <= '0;
            enable_d_reg <= 1'b0;
            if (div_wrap) begin
                dac_reg <= ~dac_reg;
            end
        end else begin
            enable_d_reg <= 1'b1;
            if (!enable_d_reg) begin
                dac_reg <= 1'b0;
            end else if (tick_reg) begin
                i1_reg  <= i1_next;
                i2_reg  <= i2_next;
                dac_reg <= ~i2_next[W_ACC-1];
            end
        end
    end

    assign tick    = tick_reg;
    assign dac_out = dac_reg;

endmodule

// File: tb/tb_apu_sdm_dac.sv
// Self-checking bench for apu_sdm_dac against an integer-arithmetic reference
// model of the interpolator and second-order modulator.
`timescale 1ns/1ps
module tb_apu_sdm_dac;

    localparam int ACC_MAX = 524287;
    localparam int ACC_MIN = -524288;
    localparam int CUR_MAX = 524287;
    localparam int CUR_MIN = -524288;

    logic               clk    = 1'b0;
    logic               rst    = 1'b1;
    logic               enable = 1'b0;
    logic               en     = 1'b0;
    logic signed [15:0] d      = '0;
    logic               tick;
    logic               dac_out;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state; cur is held in 1/16-LSB units
    int m_cur, m_step, m_target, m_phase, m_i1, m_i2;
    bit m_dac, m_tick, m_en_d;

    apu_sdm_dac #(
        .W_SAMPLE (16),
        .W_ACC    (20),
        .LOG2_OSR (4),
        .DIV      (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .en      (en),
        .d       (d),
        .tick    (tick),
        .dac_out (dac_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "time limit");
    end

    function automatic int floor16(input int a);
        return (a >= 0) ? a / 16 : -((15 - a) / 16);
    endfunction

    function automatic int clamp(input int a, input int lo, input int hi);
        return (a > hi) ? hi : ((a < lo) ? lo : a);
    endfunction

    function automatic int dut_x();
        return int'(dut.x);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_step = 0; m_target = 0; m_phase = 0;
        m_i1 = 0; m_i2 = 0; m_dac = 1'b0; m_tick = 1'b0; m_en_d = 1'b0;
    endtask

    task automatic model_update();
        int xi, v, n1, n2;
        if (rst) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_cur = 0; m_step = 0; m_target = 0; m_phase = 0;
            m_i1 = 0; m_i2 = 0;
            m_dac  = !m_dac;
            m_tick = 1'b0;
            m_en_d = 1'b0;
            return;
        end
        if (!m_en_d) begin
            m_dac = 1'b0;
        end else if (m_tick) begin
            xi = floor16(m_cur);
            v  = m_dac ? 32767 : -32768;
            n1 = clamp(m_i1 + xi - v, ACC_MIN, ACC_MAX);
            n2 = clamp(m_i2 + m_i1 - v, ACC_MIN, ACC_MAX);
            m_i1 = n1;
            m_i2 = n2;
            m_dac = (n2 >= 0);
        end
        if (m_tick) begin
            if (m_phase == 15) begin
                m_cur  = m_target * 16;
                m_step = 0;
            end else begin
                m_cur = clamp(m_cur + m_step, CUR_MIN, CUR_MAX);
            end
            m_phase = (m_phase + 1) % 16;
        end
        if (en) begin
            m_target = int'(d);
            m_step   = floor16(int'(d) * 16 - m_cur);
            m_phase  = 0;
        end
        m_en_d = 1'b1;
        m_tick = 1'b1;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Drive a constant sample with a strobe every 16 ticks; report ones and first model divergence.
    task automatic run_const(input logic signed [15:0] dv, input int n,
                             output int ones, output int first_bad);
        ones = 0;
        first_bad = -1;
        for (int c = 0; c < n; c++) begin
            en = (c % 16 == 0);
            d  = dv;
            clk_step();
            if (dac_out === 1'b1) ones++;
            if (first_bad < 0 && (dac_out !== m_dac || tick !== m_tick ||
                dut_x() != floor16(m_cur) || int'(dut.i1_reg) != m_i1 ||
                int'(dut.i2_reg) != m_i2)) begin
                first_bad = c;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; en = 1'b0; d = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (dac_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_dac_out: got %b want 0", dac_out);
        end
        n_vec++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_tick: got %b want 0", tick);
        end
        n_vec++;
        if (dut_x() !== 0) begin
            n_bad++; $display("FAIL reset_cur: got %0d want 0", dut_x());
        end
        rst = 1'b0;
        $display("test_reset: dac_out=%b tick=%b", dac_out, tick);
    endtask

    task automatic test_idle();
        logic prev;
        prev = dac_out;
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            d  = 16'($urandom);
            clk_step();
            n_vec++;
            if (dac_out !== m_dac || dac_out === prev) begin
                n_bad++;
                $display("FAIL idle_toggle: cycle %0d got %b want %b", i, dac_out, m_dac);
            end
            prev = dac_out;
        end
        en = 1'b0;
        n_vec++;
        if (dut_x() !== 0 || tick !== 1'b0) begin
            n_bad++; $display("FAIL idle_en_ignored: cur=%0d tick=%b want 0 0", dut_x(), tick);
        end
        enable = 1'b1;
        clk_step();
        n_vec++;
        if (dac_out !== 1'b0 || tick !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_restart: dac_out=%b tick=%b want 0 1", dac_out, tick);
        end
        $display("test_idle: toggled 8 cycles, restart dac_out=%b", dac_out);
    endtask

    task automatic test_interp();
        int expv;
        en = 1'b1; d = 16'sd1600;
        clk_step();
        en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            clk_step();
            expv = (k <= 16) ? 100 * k : 1600;
            n_vec++;
            if (dut_x() != expv || floor16(m_cur) != expv) begin
                n_bad++;
                $display("FAIL interp_ramp: tick %0d got %0d want %0d", k, dut_x(), expv);
            end
        end
        $display("test_interp: ramp 0 -> 1600 ends at %0d", dut_x());
    endtask

    task automatic test_retrigger();
        int x_prev, s_before, allowed;
        logic signed [15:0] d1, d2;
        for (int r = 0; r < 4; r++) begin
            d1 = 16'($signed($urandom_range(0, 40000)) - 20000);
            d2 = 16'($signed($urandom_range(0, 40000)) - 20000);
            en = 1'b1; d = d1;
            clk_step();
            en = 1'b0;
            repeat (7) clk_step();
            for (int k = 0; k < 24; k++) begin
                en = (k == 0);
                d  = d2;
                x_prev   = dut_x();
                s_before = m_step;
                clk_step();
                allowed = ((iabs(s_before) > iabs(m_step)) ? iabs(s_before) : iabs(m_step)) / 16 + 2;
                n_vec++;
                if (dut_x() != floor16(m_cur) || iabs(dut_x() - x_prev) > allowed) begin
                    n_bad++;
                    $display("FAIL retrigger_ramp: round %0d tick %0d got %0d (prev %0d) want %0d within %0d",
                             r, k, dut_x(), x_prev, floor16(m_cur), allowed);
                    break;
                end
            end
            en = 1'b0;
            $display("test_retrigger: round %0d d1=%0d d2=%0d ends at %0d", r, d1, d2, dut_x());
        end
    endtask

    task automatic test_density();
        int ones, bad;
        run_const(16'sd0, 256, ones, bad);
        n_vec++;
        if (bad != -1) begin
            n_bad++; $display("FAIL density0_settle_track: diverged at cycle %0d want none", bad);
        end
        run_const(16'sd0, 4096, ones, bad);
        n_vec++;
        if (bad != -1) begin
            n_bad++; $display("FAIL density0_track: diverged at cycle %0d want none", bad);
        end
        n_vec++;
        if (ones < 2044 || ones > 2052) begin
            n_bad++; $display("FAIL density0_ones: got %0d want 2044..2052", ones);
        end
        $display("test_density: d=0 ones=%0d/4096", ones);

        run_const(16'sh4000, 256, ones, bad);
        run_const(16'sh4000, 4096, ones, bad);
        n_vec++;
        if (bad != -1) begin
            n_bad++; $display("FAIL density75_track: diverged at cycle %0d want none", bad);
        end
        n_vec++;
        if (ones < 3052 || ones > 3092) begin
            n_bad++; $display("FAIL density75_ones: got %0d want 3052..3092", ones);
        end
        $display("test_density: d=0x4000 ones=%0d/4096", ones);
    endtask

    task automatic test_fullscale();
        int ones, bad;
        run_const(16'sh7fff, 256, ones, bad);
        run_const(16'sh7fff, 1024, ones, bad);
        n_vec++;
        if (bad != -1 || ones < 1014) begin
            n_bad++; $display("FAIL fullscale_pos: ones=%0d diverge=%0d want >=1014 and none", ones, bad);
        end
        $display("test_fullscale: d=0x7fff ones=%0d/1024", ones);
        run_const(16'sh8000, 256, ones, bad);
        run_const(16'sh8000, 1024, ones, bad);
        n_vec++;
        if (bad != -1 || ones > 10) begin
            n_bad++; $display("FAIL fullscale_neg: ones=%0d diverge=%0d want <=10 and none", ones, bad);
        end
        $display("test_fullscale: d=0x8000 ones=%0d/1024", ones);
        run_const(16'sd0, 256, ones, bad);
        n_vec++;
        if (bad != -1) begin
            n_bad++; $display("FAIL recovery_track: diverged at cycle %0d want none", bad);
        end
        run_const(16'sd0, 1024, ones, bad);
        n_vec++;
        if (bad != -1 || ones < 502 || ones > 522) begin
            n_bad++; $display("FAIL recovery_ones: ones=%0d diverge=%0d want 502..522 and none", ones, bad);
        end
        $display("test_fullscale: recovery d=0 ones=%0d/1024", ones);
    endtask

    task automatic test_random();
        int gap;
        logic signed [15:0] dv;
        for (int t = 0; t < 30; t++) begin
            gap = $urandom_range(1, 24);
            case ($urandom_range(0, 7))
                0:       dv = 16'sh7fff;
                1:       dv = 16'sh8000;
                default: dv = 16'($urandom);
            endcase
            for (int c = 0; c < gap; c++) begin
                en = (c == 0);
                d  = dv;
                clk_step();
                n_vec++;
                if (dac_out !== m_dac || tick !== m_tick || dut_x() != floor16(m_cur) ||
                    int'(dut.i1_reg) != m_i1 || int'(dut.i2_reg) != m_i2) begin
                    n_bad++;
                    $display("FAIL random_track: txn %0d cycle %0d dac=%b/%b x=%0d/%0d i1=%0d/%0d i2=%0d/%0d (got/want)",
                             t, c, dac_out, m_dac, dut_x(), floor16(m_cur),
                             int'(dut.i1_reg), m_i1, int'(dut.i2_reg), m_i2);
                    break;
                end
            end
            en = 1'b0;
            $display("test_random: txn %0d d=%0d gap=%0d x=%0d", t, dv, gap, dut_x());
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; d = 16'sd12000;
        clk_step();
        en = 1'b0;
        repeat (5) clk_step();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (dac_out !== 1'b0 || tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_outputs: dac_out=%b tick=%b want 0 0", dac_out, tick);
        end
        n_vec++;
        if (dut_x() !== 0 || int'(dut.i1_reg) !== 0 || int'(dut.i2_reg) !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_state: cur=%0d i1=%0d i2=%0d want 0 0 0",
                     dut_x(), int'(dut.i1_reg), int'(dut.i2_reg));
        end
        model_reset();
        repeat (3) clk_step();
        rst = 1'b0;
        for (int c = 0; c < 48; c++) begin
            en = (c % 16 == 0);
            d  = -16'sd9000;
            clk_step();
            n_vec++;
            if (dac_out !== m_dac || tick !== m_tick || dut_x() != floor16(m_cur) ||
                int'(dut.i1_reg) != m_i1 || int'(dut.i2_reg) != m_i2) begin
                n_bad++;
                $display("FAIL reset_mid_restart: cycle %0d dac=%b/%b x=%0d/%0d i1=%0d/%0d (got/want)",
                         c, dac_out, m_dac, dut_x(), floor16(m_cur), int'(dut.i1_reg), m_i1);
                break;
            end
        end
        en = 1'b0;
        $display("test_reset_mid: restart from fresh state, x=%0d", dut_x());
    endtask

    initial begin
        test_reset();
        test_idle();
        test_interp();
        test_retrigger();
        test_density();
        test_fullscale();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
